// File: rtl/udma_sdio_cmd_seq_if.sv
// Config-bus interface between the SD command sequencer (master) and the
// SDIO uDMA register port (slave). The _o/_i suffixes are relative to the
// sequencer.
interface udma_sdio_cmd_seq_if;
  logic [31:0] cfg_data_o;
  logic [4:0]  cfg_addr_o;
  logic        cfg_valid_o;
  logic        cfg_rwn_o;
  logic [31:0] cfg_data_i;
  logic        cfg_ready_i;

  modport master (
    output cfg_data_o,
    output cfg_addr_o,
    output cfg_valid_o,
    output cfg_rwn_o,
    input  cfg_data_i,
    input  cfg_ready_i
  );

  modport slave (
    input  cfg_data_o,
    input  cfg_addr_o,
    input  cfg_valid_o,
    input  cfg_rwn_o,
    output cfg_data_i,
    output cfg_ready_i
  );
endinterface

// File: rtl/udma_sdio_cmd_seq.sv
// SD command sequencer for the SDIO uDMA 5-bit config bus.
// Programs CMD_OP / CMD_ARG / DATA_SETUP, pulses START, polls STATUS with a
// gap between reads, clears STATUS and optionally fetches the 4 response words.
// Optional poll timeout: define SDIO_CMD_SEQ_TIMEOUT_EN.
module udma_sdio_cmd_seq #(
  parameter int unsigned           POLL_GAP   = 4,
  parameter int unsigned           POLL_CNT_W = 16,
  parameter logic [POLL_CNT_W-1:0] POLL_MAX   = 16'hFFFF
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [5:0]   req_cmd_op_i,
  input  logic [2:0]   req_rsp_type_i,
  input  logic [1:0]   req_stopopt_i,
  input  logic [31:0]  req_arg_i,
  input  logic [20:0]  req_data_setup_i,
  output logic         done_valid_o,
  input  logic         done_ready_i,
  output logic [15:0]  done_status_o,
  output logic         done_err_o,
  output logic         done_timeout_o,
  output logic [127:0] done_rsp_o,
  udma_sdio_cmd_seq_if.master cfg
);

  localparam logic [4:0] A_CMD_OP  = 5'h08;
  localparam logic [4:0] A_CMD_ARG = 5'h09;
  localparam logic [4:0] A_SETUP   = 5'h0A;
  localparam logic [4:0] A_START   = 5'h0B;
  localparam logic [4:0] A_RSP0    = 5'h0C;
  localparam logic [4:0] A_STATUS  = 5'h11;

  localparam int unsigned     GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_OP, S_WR_ARG, S_WR_SETUP, S_WR_START,
    S_GAP, S_POLL, S_CLR, S_RD_RSP, S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [5:0]  r_cmd_op;
  logic [2:0]  r_rsp_type;
  logic [1:0]  r_stopopt;
  logic [31:0] r_arg;
  logic [20:0] r_setup;

  logic [GAP_W-1:0]      r_gap_cnt;
  logic [POLL_CNT_W-1:0] r_poll_cnt;
  logic [1:0]            r_rsp_idx;
  logic [1:0]            w_rsp_idx_next;

  logic [31:0] r_cfg_data;
  logic [4:0]  r_cfg_addr;
  logic        r_cfg_valid;
  logic        r_cfg_rwn;
  logic [31:0] w_cfg_data_next;
  logic [4:0]  w_cfg_addr_next;
  logic        w_cfg_valid_next;
  logic        w_cfg_rwn_next;

  logic [15:0] r_done_status;
  logic        r_done_err;

  logic        w_accept;
  logic        w_xfer;
  logic        w_stat_hit;
  logic        w_timeout_hit;
  logic        w_timed_out;
  logic        w_poll_xfer;
  logic [5:0]  w_op;
  logic [2:0]  w_rsp_type;
  logic [1:0]  w_stopopt;

  assign w_accept    = req_valid_i & (r_state == S_IDLE);
  assign w_xfer      = r_cfg_valid & cfg.cfg_ready_i;
  assign w_stat_hit  = cfg.cfg_data_i[0] | cfg.cfg_data_i[1];
  assign w_poll_xfer = (r_state == S_POLL) & w_xfer;

  // The CMD_OP word is built the same cycle the request is captured.
  assign w_op       = w_accept ? req_cmd_op_i   : r_cmd_op;
  assign w_rsp_type = w_accept ? req_rsp_type_i : r_rsp_type;
  assign w_stopopt  = w_accept ? req_stopopt_i  : r_stopopt;

`ifdef SDIO_CMD_SEQ_TIMEOUT_EN
  logic r_done_timeout;

  assign w_timeout_hit = ~w_stat_hit & (r_poll_cnt == POLL_CNT_W'(POLL_MAX - 1'b1));

  // Timeout flag: cleared on acceptance, set when the poll budget runs out.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_done_timeout <= 1'b0;
    end else if (w_accept) begin
      r_done_timeout <= 1'b0;
    end else if (w_poll_xfer && w_timeout_hit) begin
      r_done_timeout <= 1'b1;
    end
  end

  assign done_timeout_o = r_done_timeout;
`else
  assign w_timeout_hit  = 1'b0;
  assign done_timeout_o = 1'b0;
`endif

  assign w_timed_out = done_timeout_o;

  // State register.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; bus states advance only on an accepted transaction.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:     if (w_accept) w_state_next = S_WR_OP;
      S_WR_OP:    if (w_xfer) w_state_next = S_WR_ARG;
      S_WR_ARG:   if (w_xfer) w_state_next = S_WR_SETUP;
      S_WR_SETUP: if (w_xfer) w_state_next = S_WR_START;
      S_WR_START: if (w_xfer) w_state_next = (POLL_GAP == 0) ? S_POLL : S_GAP;
      S_GAP:      if (r_gap_cnt == GAP_LAST) w_state_next = S_POLL;
      S_POLL: begin
        if (w_xfer) begin
          if (w_stat_hit || w_timeout_hit) w_state_next = S_CLR;
          else                             w_state_next = (POLL_GAP == 0) ? S_POLL : S_GAP;
        end
      end
      S_CLR: begin
        if (w_xfer) begin
          if ((r_rsp_type != 3'd0) && !r_done_err && !w_timed_out) w_state_next = S_RD_RSP;
          else                                                     w_state_next = S_DONE;
        end
      end
      S_RD_RSP:   if (w_xfer && (r_rsp_idx == 2'd3)) w_state_next = S_DONE;
      S_DONE:     if (done_ready_i) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  // Output logic: cfg bus values for the state being entered, registered below.
  always_comb begin
    w_rsp_idx_next   = r_rsp_idx;
    w_cfg_valid_next = 1'b0;
    w_cfg_addr_next  = 5'h00;
    w_cfg_data_next  = 32'h0;
    w_cfg_rwn_next   = 1'b0;
    if (r_state == S_CLR) begin
      w_rsp_idx_next = 2'd0;
    end else if ((r_state == S_RD_RSP) && w_xfer) begin
      w_rsp_idx_next = r_rsp_idx + 2'd1;
    end
    unique case (w_state_next)
      S_WR_OP: begin
        w_cfg_valid_next = 1'b1;
        w_cfg_addr_next  = A_CMD_OP;
        w_cfg_data_next  = {14'b0, w_stopopt, 2'b0, w_op, 5'b0, w_rsp_type};
      end
      S_WR_ARG: begin
        w_cfg_valid_next = 1'b1;
        w_cfg_addr_next  = A_CMD_ARG;
        w_cfg_data_next  = r_arg;
      end
      S_WR_SETUP: begin
        w_cfg_valid_next = 1'b1;
        w_cfg_addr_next  = A_SETUP;
        w_cfg_data_next  = {6'b0, r_setup[20:11], r_setup[10:3], 5'b0, r_setup[2:0]};
      end
      S_WR_START: begin
        w_cfg_valid_next = 1'b1;
        w_cfg_addr_next  = A_START;
        w_cfg_data_next  = 32'h1;
      end
      S_POLL: begin
        w_cfg_valid_next = 1'b1;
        w_cfg_addr_next  = A_STATUS;
        w_cfg_rwn_next   = 1'b1;
      end
      S_CLR: begin
        w_cfg_valid_next = 1'b1;
        w_cfg_addr_next  = A_STATUS;
        w_cfg_data_next  = 32'h3;
      end
      S_RD_RSP: begin
        w_cfg_valid_next = 1'b1;
        w_cfg_addr_next  = A_RSP0 + {3'b0, w_rsp_idx_next};
        w_cfg_rwn_next   = 1'b1;
      end
      default: begin
        w_cfg_valid_next = 1'b0;
      end
    endcase
  end

  // Registered cfg bus outputs and response word index.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_cfg_valid <= 1'b0;
      r_cfg_addr  <= 5'h00;
      r_cfg_data  <= 32'h0;
      r_cfg_rwn   <= 1'b0;
      r_rsp_idx   <= 2'd0;
    end else begin
      r_cfg_valid <= w_cfg_valid_next;
      r_cfg_addr  <= w_cfg_addr_next;
      r_cfg_data  <= w_cfg_data_next;
      r_cfg_rwn   <= w_cfg_rwn_next;
      r_rsp_idx   <= w_rsp_idx_next;
    end
  end

  // Request capture, gap/poll counters and STATUS capture.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_cmd_op      <= 6'd0;
      r_rsp_type    <= 3'd0;
      r_stopopt     <= 2'd0;
      r_arg         <= 32'h0;
      r_setup       <= 21'h0;
      r_gap_cnt     <= '0;
      r_poll_cnt    <= '0;
      r_done_status <= 16'h0;
      r_done_err    <= 1'b0;
    end else begin
      r_gap_cnt <= (r_state == S_GAP) ? r_gap_cnt + 1'b1 : '0;
      if (w_accept) begin
        r_cmd_op      <= req_cmd_op_i;
        r_rsp_type    <= req_rsp_type_i;
        r_stopopt     <= req_stopopt_i;
        r_arg         <= req_arg_i;
        r_setup       <= req_data_setup_i;
        r_poll_cnt    <= '0;
        r_done_status <= 16'h0;
        r_done_err    <= 1'b0;
      end else if (w_poll_xfer) begin
        if (w_stat_hit) begin
          r_done_status <= cfg.cfg_data_i[31:16];
          r_done_err    <= cfg.cfg_data_i[1];
        end else if (w_timeout_hit) begin
          r_done_status <= 16'h0;
        end else if (r_poll_cnt != '1) begin
          r_poll_cnt <= r_poll_cnt + 1'b1;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rsp
      logic [31:0] r_rsp_word;

      // Response word gi: cleared on acceptance, loaded by its RD_RSP read.
      always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
          r_rsp_word <= 32'h0;
        end else if (w_accept) begin
          r_rsp_word <= 32'h0;
        end else if ((r_state == S_RD_RSP) && w_xfer && (r_rsp_idx == 2'(gi))) begin
          r_rsp_word <= cfg.cfg_data_i;
        end
      end

      assign done_rsp_o[32*gi +: 32] = r_rsp_word;
    end
  endgenerate

  assign req_ready_o     = (r_state == S_IDLE);
  assign done_valid_o    = (r_state == S_DONE);
  assign done_status_o   = r_done_status;
  assign done_err_o      = r_done_err;
  assign cfg.cfg_valid_o = r_cfg_valid;
  assign cfg.cfg_addr_o  = r_cfg_addr;
  assign cfg.cfg_data_o  = r_cfg_data;
  assign cfg.cfg_rwn_o   = r_cfg_rwn;

endmodule
